regfile_mp: RTL and testbench

//  Parametrised multi-port register file for the MIPS pipeline: NUM_RD async read ports, NUM_WR write ports.

---
 rtl/regfile_mp_pkg.sv | 11 +
 rtl/regfile_scoreboard.sv | 35 +++
 rtl/regfile_mp.sv | 84 ++++++++
 tb/tb_regfile_mp.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package regfile_mp_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: a write-back clears, an issue sets, and the set wins a same-cycle tie.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  output logic [(2**ADDR_W)-1:0]   busy_vec
);

  logic [(2**ADDR_W)-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy_vec;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) busy_nxt[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
    end
    // Applied after the clears so a newer producer is never lost.
    if (iss_en) busy_nxt[iss_addr] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_vec <= '0;
    else        busy_vec <= busy_nxt;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional zero register, write-to-read bypass and busy scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [(2**ADDR_W)-1:0]   busy_vec
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  // Later ports overwrite earlier ones inside the loop, giving the higher index priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && !(ZERO_REG != 0 && wr_addr[j*ADDR_W +: ADDR_W] == '0))
          mem[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_WR  (NUM_WR),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .iss_en  (iss_en),
    .iss_addr(iss_addr),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .busy_vec(busy_vec)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign raddr = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      data = mem[raddr];
      busy = busy_vec[raddr];
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == raddr) begin
            data = wr_data[j*DATA_W +: DATA_W];
            busy = 1'b0;
          end
        end
      end
      // Zero register and reset both dominate any forwarded value.
      if ((ZERO_REG != 0 && raddr == '0) || !rst_n) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
    assign rd_busy[k]                  = busy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard-driven bench for regfile_mp, with a bypassing and a non-bypassing instance.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;

  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic [31:0] busy_vec_b, busy_vec_n;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_data_q [$];
  logic        exp_busy_q [$];
  logic [31:0] e;
  logic        eb;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_vec(busy_vec_b)
  );

  regfile_mp #(.BYPASS(0)) u_nob (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_vec(busy_vec_n)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 2'b00;
    iss_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); rd_addr = {5'd6, 5'd5}; wr_addr = '0; wr_data = '0; iss_addr = '0;
    step(); step();
    exp_data_q.push_back(32'h0); exp_data_q.push_back(32'h0);
    e = exp_data_q.pop_front(); checks++;
    if (rd_data_b[31:0] !== e) begin errors++; $display("FAIL reset_rd0 got %h want %h", rd_data_b[31:0], e); end
    checks++;
    if (busy_vec_b !== 32'h0) begin errors++; $display("FAIL reset_busy got %h want 0", busy_vec_b); end
    rst_n = 1'b1;
    wr_en = 2'b11; wr_addr = {5'd6, 5'd5}; wr_data = {32'h2222, 32'h1111}; iss_en = 1'b1; iss_addr = 5'd4;
    step();
    idle(); #2;
    rst_n = 1'b0; #1;
    e = exp_data_q.pop_front(); checks++;
    if (rd_data_b[31:0] !== e || rd_data_b[63:32] !== e)
      begin errors++; $display("FAIL reset_async_data got %h want %h", rd_data_b, {e, e}); end
    checks++;
    if (busy_vec_b !== 32'h0) begin errors++; $display("FAIL reset_async_busy got %h want 0", busy_vec_b); end
    wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'h7777};
    step();
    idle(); rst_n = 1'b1; rd_addr = {5'd7, 5'd7};
    exp_data_q.push_back(32'h0);
    #2;
    e = exp_data_q.pop_front(); checks++;
    if (rd_data_n[31:0] !== e) begin errors++; $display("FAIL reset_drop_write got %h want %h", rd_data_n[31:0], e); end
  endtask

  task automatic test_write();
    step();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
    step();
    idle(); rd_addr = {5'd5, 5'd5};
    exp_data_q.push_back(32'hDEADBEEF); exp_data_q.push_back(32'hDEADBEEF);
    #2;
    e = exp_data_q.pop_front(); checks++;
    if (rd_data_n[31:0] !== e) begin errors++; $display("FAIL write_port0 got %h want %h", rd_data_n[31:0], e); end
    e = exp_data_q.pop_front(); checks++;
    if (rd_data_n[63:32] !== e) begin errors++; $display("FAIL write_port1 got %h want %h", rd_data_n[63:32], e); end
  endtask

  task automatic test_zero();
    wr_en = 2'b10; wr_addr = {5'd0, 5'd0}; wr_data = {32'h1234, 32'h0};
    iss_en = 1'b1; iss_addr = 5'd0; rd_addr = {5'd0, 5'd0};
    exp_data_q.push_back(32'h0); exp_data_q.push_back(32'h0);
    #2;
    e = exp_data_q.pop_front(); checks++;
    if (rd_data_b[63:32] !== e) begin errors++; $display("FAIL zero_bypass got %h want %h", rd_data_b[63:32], e); end
    step();
    idle(); #2;
    e = exp_data_q.pop_front(); checks++;
    if (rd_data_n[31:0] !== e) begin errors++; $display("FAIL zero_read got %h want %h", rd_data_n[31:0], e); end
    checks++;
    if (busy_vec_b[0] !== 1'b0) begin errors++; $display("FAIL zero_busy got %b want 0", busy_vec_b[0]); end
  endtask

  task automatic test_conflict();
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'hBBBB, 32'hAAAA}; rd_addr = {5'd7, 5'd7};
    exp_data_q.push_back(32'hBBBB); exp_data_q.push_back(32'hBBBB);
    #2;
    e = exp_data_q.pop_front(); checks++;
    if (rd_data_b[31:0] !== e) begin errors++; $display("FAIL conflict_bypass got %h want %h", rd_data_b[31:0], e); end
    step();
    idle(); #2;
    e = exp_data_q.pop_front(); checks++;
    if (rd_data_n[63:32] !== e) begin errors++; $display("FAIL conflict_read got %h want %h", rd_data_n[63:32], e); end
  endtask

  task automatic test_bypass();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h11};
    step();
    idle(); iss_en = 1'b1; iss_addr = 5'd9;
    step();
    idle(); wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h55, 32'h0}; rd_addr = {5'd9, 5'd9};
    exp_data_q.push_back(32'h55); exp_busy_q.push_back(1'b0);
    exp_data_q.push_back(32'h11); exp_busy_q.push_back(1'b1);
    exp_data_q.push_back(32'h55); exp_busy_q.push_back(1'b0);
    #2;
    e = exp_data_q.pop_front(); eb = exp_busy_q.pop_front(); checks++;
    if (rd_data_b[31:0] !== e || rd_busy_b[0] !== eb)
      begin errors++; $display("FAIL bypass_on got %h/%b want %h/%b", rd_data_b[31:0], rd_busy_b[0], e, eb); end
    e = exp_data_q.pop_front(); eb = exp_busy_q.pop_front(); checks++;
    if (rd_data_n[31:0] !== e || rd_busy_n[0] !== eb)
      begin errors++; $display("FAIL bypass_off got %h/%b want %h/%b", rd_data_n[31:0], rd_busy_n[0], e, eb); end
    step();
    idle(); #2;
    e = exp_data_q.pop_front(); eb = exp_busy_q.pop_front(); checks++;
    if (rd_data_n[63:32] !== e || rd_busy_n[1] !== eb)
      begin errors++; $display("FAIL bypass_off_next got %h/%b want %h/%b", rd_data_n[63:32], rd_busy_n[1], e, eb); end
  endtask

  task automatic test_scoreboard();
    iss_en = 1'b1; iss_addr = 5'd3; rd_addr = {5'd3, 5'd3};
    step();
    idle(); step(); step();
    exp_busy_q.push_back(1'b1); exp_busy_q.push_back(1'b0); exp_busy_q.push_back(1'b0);
    #2;
    eb = exp_busy_q.pop_front(); checks++;
    if (rd_busy_b[0] !== eb || busy_vec_b[3] !== eb)
      begin errors++; $display("FAIL sb_issue got %b/%b want %b", rd_busy_b[0], busy_vec_b[3], eb); end
    wr_en = 2'b10; wr_addr = {5'd3, 5'd0}; wr_data = {32'h3333, 32'h0};
    #1;
    eb = exp_busy_q.pop_front(); checks++;
    if (rd_busy_b[1] !== eb) begin errors++; $display("FAIL sb_wb_bypass got %b want %b", rd_busy_b[1], eb); end
    step();
    idle(); #2;
    eb = exp_busy_q.pop_front(); checks++;
    if (busy_vec_n[3] !== eb) begin errors++; $display("FAIL sb_wb_clear got %b want %b", busy_vec_n[3], eb); end
    iss_en = 1'b1; iss_addr = 5'd3; wr_en = 2'b01; wr_addr = {5'd0, 5'd3};
    exp_busy_q.push_back(1'b1); exp_busy_q.push_back(1'b1); exp_busy_q.push_back(1'b0);
    step();
    idle(); #2;
    eb = exp_busy_q.pop_front(); checks++;
    if (busy_vec_b[3] !== eb) begin errors++; $display("FAIL sb_set_wins got %b want %b", busy_vec_b[3], eb); end
    iss_en = 1'b1; iss_addr = 5'd3;
    step();
    idle(); #2;
    eb = exp_busy_q.pop_front(); checks++;
    if (busy_vec_n[3] !== eb) begin errors++; $display("FAIL sb_reissue got %b want %b", busy_vec_n[3], eb); end
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3};
    step();
    idle(); #2;
    eb = exp_busy_q.pop_front(); checks++;
    if (busy_vec_b[3] !== eb) begin errors++; $display("FAIL sb_single_bit got %b want %b", busy_vec_b[3], eb); end
    checks++;
    if (busy_vec_b !== 32'h0) begin errors++; $display("FAIL sb_final_vec got %h want 0", busy_vec_b); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_zero();
    test_conflict();
    test_bypass();
    test_scoreboard();
    checks++;
    if (exp_data_q.size() != 0 || exp_busy_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d/%0d want 0/0", exp_data_q.size(), exp_busy_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
